// File: rtl/hist_frame_sched.sv
// Frame-level sequencer for the CFAR histogram threshold datapath: gates one
// frame of amplitude rows into the histogram engine and collects its per-row thresholds.
module hist_frame_sched #(
  parameter int unsigned ROWS    = 2048,
  parameter int unsigned COLS    = 64,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk_100mhz,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic [1:0]  cfg_bin_select,
  input  logic [2:0]  cfg_db_select,
  input  logic        s_tvalid,
  input  logic [31:0] s_tdata,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic        m_tvalid,
  output logic [31:0] m_tdata,
  output logic        m_tlast,
  output logic [1:0]  hist_bin_select_o,
  output logic [2:0]  hist_db_select_o,
  input  logic        thr_vld_i,
  input  logic [15:0] thr_data_i,
  output logic        thr_wr_en,
  output logic [10:0] thr_wr_addr,
  output logic [15:0] thr_wr_data,
  output logic        busy,
  output logic        frame_done,
  output logic        len_err,
  output logic        timeout_err,
  output logic        overrun_err
);

  localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] ROWS_C   = CNT_W'(ROWS);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CFG    = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] thr_cnt_q, thr_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             s_tready_q, s_tready_d;
  logic             m_tvalid_q, m_tvalid_d;
  logic [31:0]      m_tdata_q, m_tdata_d;
  logic             m_tlast_q, m_tlast_d;
  logic [1:0]       bin_q, bin_d;
  logic [2:0]       db_q, db_d;
  logic             wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]      wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             len_err_q, len_err_d;
  logic             tmo_err_q, tmo_err_d;
  logic             ovr_err_q, ovr_err_d;

  logic accept;
  logic hs;
  logic col_last;
  logic capture_ok;

  // Next-state and output decode
  always_comb begin
    accept     = (state_q == S_IDLE) && frame_start;
    hs         = s_tvalid && s_tready_q;
    col_last   = (col_q == COL_LAST);
    capture_ok = (state_q == S_STREAM) || (state_q == S_DRAIN) || (state_q == S_DONE);

    state_d    = state_q;
    col_d      = accept ? '0 : col_q;
    row_d      = accept ? '0 : row_q;
    thr_cnt_d  = accept ? '0 : thr_cnt_q;
    tmo_d      = accept ? '0 : tmo_q;
    m_tvalid_d = 1'b0;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = 1'b0;
    bin_d      = accept ? cfg_bin_select : bin_q;
    db_d       = accept ? cfg_db_select : db_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    len_err_d  = accept ? 1'b0 : len_err_q;
    tmo_err_d  = accept ? 1'b0 : tmo_err_q;
    ovr_err_d  = accept ? 1'b0 : ovr_err_q;

    // Threshold capture; anything outside a frame or past ROWS is an overrun
    if (thr_vld_i) begin
      if (capture_ok && (thr_cnt_q != ROWS_C)) begin
        wr_en_d   = 1'b1;
        wr_addr_d = thr_cnt_q[ADDR_W-1:0];
        wr_data_d = thr_data_i;
        thr_cnt_d = thr_cnt_q + CNT_W'(1);
      end else begin
        ovr_err_d = 1'b1;
      end
    end

    if (frame_start && (state_q != S_IDLE)) begin
      ovr_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_CFG;
        end
      end
      S_CFG: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (hs) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = s_tdata;
          m_tlast_d  = col_last;
          if (s_tlast != col_last) begin
            len_err_d = 1'b1;
          end
          if (col_last) begin
            col_d = '0;
            row_d = row_q + CNT_W'(1);
            if (row_q == ROW_LAST) begin
              state_d = S_DRAIN;
              tmo_d   = '0;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // A write landing this cycle counts toward completion
        if (thr_cnt_d == ROWS_C) begin
          state_d = S_DONE;
        end else if ((tmo_q + TMO_W'(1)) == TMO_MAX) begin
          tmo_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    s_tready_d = (state_d == S_STREAM);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk_100mhz) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      thr_cnt_q  <= '0;
      tmo_q      <= '0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      bin_q      <= '0;
      db_q       <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      thr_cnt_q  <= thr_cnt_d;
      tmo_q      <= tmo_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      bin_q      <= bin_d;
      db_q       <= db_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      len_err_q  <= len_err_d;
      tmo_err_q  <= tmo_err_d;
      ovr_err_q  <= ovr_err_d;
    end
  end

  assign s_tready          = s_tready_q;
  assign m_tvalid          = m_tvalid_q;
  assign m_tdata           = m_tdata_q;
  assign m_tlast           = m_tlast_q;
  assign hist_bin_select_o = bin_q;
  assign hist_db_select_o  = db_q;
  assign thr_wr_en         = wr_en_q;
  assign thr_wr_addr       = wr_addr_q;
  assign thr_wr_data       = wr_data_q;
  assign busy              = busy_q;
  assign frame_done        = done_q;
  assign len_err           = len_err_q;
  assign timeout_err       = tmo_err_q;
  assign overrun_err       = ovr_err_q;

endmodule
